// File: rtl/ring_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ring_shift_ctrl_pkg
// Brief  : Mode-select codes, FSM encoding and shadow rotate helper.
// Rev    : 1.0
// ============================================================================
package ring_shift_ctrl_pkg;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_ROTL = 2'b01;
  localparam logic [1:0] S_ROTR = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_STEP = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Same rotate rule as the downstream register: right = 1 rotates toward bit 0.
  function automatic logic [3:0] rot4(input logic [3:0] v, input logic right);
    return right ? {v[0], v[3:1]} : {v[2:0], v[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_shift_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ring_shift_ctrl_if
// Brief  : Command inputs and register-control outputs of ring_shift_ctrl.
// Rev    : 1.0
// ============================================================================
interface ring_shift_ctrl_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic [3:0] pat;
  logic [3:0] steps;
  logic [1:0] s;
  logic [3:0] d;
  logic       oe;
  logic       busy;
  logic       done;
  logic [3:0] shadow;

  modport master (
    output start, stop, dir, pat, steps,
    input  s, d, oe, busy, done, shadow
  );

  modport slave (
    input  start, stop, dir, pat, steps,
    output s, d, oe, busy, done, shadow
  );
endinterface
`default_nettype wire

// File: rtl/ring_shift_ctrl_step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : step_tick_gen
// Brief  : Prescaler with clear/enable; tc flags a count of TICK_DIV-1.
// Rev    : 1.0
// ============================================================================
module step_tick_gen #(
  parameter int TICK_DIV = 4,
  parameter int TICK_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TICK_W-1:0] c_tc = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (en)
      r_count <= r_count + 1'b1;
  end

  assign tc = (r_count == c_tc);

endmodule
`default_nettype wire

// File: rtl/ring_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ring_shift_ctrl
// Brief  : Load-then-rotate sequencer for a 4-bit rotate/load register.
// Rev    : 1.0
// ============================================================================
module ring_shift_ctrl
  import ring_shift_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int TICK_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  ring_shift_ctrl_if.slave    bus
);

  state_t     r_state, w_next;
  logic [3:0] r_pat;
  logic       r_dir;
  logic [3:0] r_remain;
  logic [3:0] r_shadow;
  logic       r_oe;

  logic [1:0] w_s;
  logic       w_busy, w_done;
  logic       w_tick_clr, w_tick_en, w_tick_tc;
  logic       w_latch, w_load_fire, w_step_fire;

  step_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_tick_clr),
    .en  (w_tick_en),
    .tc  (w_tick_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // STOP suppresses every command issued in its cycle, so it is tested first.
  always_comb begin
    w_next      = r_state;
    w_s         = S_HOLD;
    w_busy      = (r_state != ST_IDLE);
    w_done      = 1'b0;
    w_tick_clr  = 1'b1;
    w_tick_en   = 1'b0;
    w_latch     = 1'b0;
    w_load_fire = 1'b0;
    w_step_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_latch = 1'b1;
          w_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.stop) begin
          w_next = ST_IDLE;
        end else begin
          w_s         = S_LOAD;
          w_load_fire = 1'b1;
          w_next      = (r_remain == 4'd0) ? ST_FIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.stop) begin
          w_next = ST_IDLE;
        end else begin
          w_tick_clr = 1'b0;
          w_tick_en  = 1'b1;
          if (w_tick_tc)
            w_next = ST_STEP;
        end
      end
      ST_STEP: begin
        if (bus.stop) begin
          w_next = ST_IDLE;
        end else begin
          w_s         = r_dir ? S_ROTR : S_ROTL;
          w_step_fire = 1'b1;
          w_next      = (r_remain == 4'd1) ? ST_FIN : ST_WAIT;
        end
      end
      ST_FIN: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat    <= 4'd0;
      r_dir    <= 1'b0;
      r_remain <= 4'd0;
      r_shadow <= 4'd0;
      r_oe     <= 1'b1;
    end else begin
      if (w_latch) begin
        r_pat    <= bus.pat;
        r_dir    <= bus.dir;
        r_remain <= bus.steps;
      end
      if (w_load_fire) begin
        r_shadow <= r_pat;
        r_oe     <= 1'b0;
      end
      if (w_step_fire) begin
        r_shadow <= rot4(r_shadow, r_dir);
        r_remain <= r_remain - 4'd1;
      end
    end
  end

  assign bus.s      = w_s;
  assign bus.d      = r_pat;
  assign bus.oe     = r_oe;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.shadow = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_ring_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ring_shift_ctrl
// Brief  : Directed, table-driven bench for ring_shift_ctrl (TICK_DIV 2 and 1).
// Rev    : 1.0
// ============================================================================
module tb_ring_shift_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ring_shift_ctrl_if bus2 ();
  ring_shift_ctrl_if bus1 ();

  ring_shift_ctrl #(.TICK_DIV(2), .TICK_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  ring_shift_ctrl #(.TICK_DIV(1), .TICK_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Behavioural model of the downstream rotate/load register fed by dut2.
  logic [3:0] reg_q = 4'd0;
  always @(posedge clk) begin
    case (bus2.s)
      2'b11: reg_q <= bus2.d;
      2'b01: reg_q <= {reg_q[2:0], reg_q[3]};
      2'b10: reg_q <= {reg_q[0], reg_q[3:1]};
      default: reg_q <= reg_q;
    endcase
  end

  typedef struct {
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic       oe;
    logic [3:0] shadow;
  } row_t;

  row_t rows[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start2(input logic [3:0] pat, input logic dir, input logic [3:0] steps);
    @(negedge clk);
    bus2.pat = pat; bus2.dir = dir; bus2.steps = steps; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  logic [3:0] exp1[5];
  int busy_cnt, rot_idx, rot_seen;
  logic pend;

  initial begin
    // PAT=0001 DIR=0 STEPS=3, TICK_DIV=2: {s, busy, done, oe, shadow} per cycle from LOAD
    rows[0]  = '{2'b11, 1'b1, 1'b0, 1'b1, 4'b0000};
    rows[1]  = '{2'b00, 1'b1, 1'b0, 1'b0, 4'b0001};
    rows[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 4'b0001};
    rows[3]  = '{2'b01, 1'b1, 1'b0, 1'b0, 4'b0001};
    rows[4]  = '{2'b00, 1'b1, 1'b0, 1'b0, 4'b0010};
    rows[5]  = '{2'b00, 1'b1, 1'b0, 1'b0, 4'b0010};
    rows[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 4'b0010};
    rows[7]  = '{2'b00, 1'b1, 1'b0, 1'b0, 4'b0100};
    rows[8]  = '{2'b00, 1'b1, 1'b0, 1'b0, 4'b0100};
    rows[9]  = '{2'b01, 1'b1, 1'b0, 1'b0, 4'b0100};
    rows[10] = '{2'b00, 1'b1, 1'b1, 1'b0, 4'b1000};
    rows[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 4'b1000};
    exp1[0] = 4'b0100; exp1[1] = 4'b0010; exp1[2] = 4'b0001;
    exp1[3] = 4'b1000; exp1[4] = 4'b0100;

    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.dir = 1'b0; bus2.pat = 4'd0; bus2.steps = 4'd0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.dir = 1'b0; bus1.pat = 4'd0; bus1.steps = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle2_%0d", i), {bus2.s, bus2.d, bus2.oe, bus2.busy, bus2.done, bus2.shadow},
          {2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000});
      chk($sformatf("idle1_%0d", i), {bus1.s, bus1.oe, bus1.busy, bus1.shadow},
          {2'b00, 1'b1, 1'b0, 4'b0000});
    end

    // Table-driven 3-step left run
    start2(4'b0001, 1'b0, 4'd3);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("row%0d", i), {bus2.s, bus2.busy, bus2.done, bus2.oe, bus2.shadow},
          {rows[i].s, rows[i].busy, rows[i].done, rows[i].oe, rows[i].shadow});
      if (i > 0) chk($sformatf("regq_row%0d", i), reg_q, rows[i].shadow);
    end
    chk("run1_d", bus2.d, 4'b0001);

    // TICK_DIV=1, right rotation, 5 steps
    @(negedge clk);
    bus1.pat = 4'b1000; bus1.dir = 1'b1; bus1.steps = 4'd5; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    busy_cnt = 0; rot_idx = 0; pend = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus1.busy) busy_cnt++;
      if (pend && rot_idx < 5) begin
        chk($sformatf("run1r_shadow%0d", rot_idx), bus1.shadow, exp1[rot_idx]);
        rot_idx++;
        pend = 1'b0;
      end
      if (bus1.s == 2'b10) pend = 1'b1;
      @(negedge clk);
    end
    chk("run1r_busy_cycles", busy_cnt, 12);
    chk("run1r_rotations", rot_idx, 5);

    // STEPS=0: load then straight to FIN
    start2(4'b1010, 1'b0, 4'd0);
    chk("z_load", {bus2.s, bus2.d, bus2.done}, {2'b11, 4'b1010, 1'b0});
    @(negedge clk);
    chk("z_fin", {bus2.s, bus2.busy, bus2.done, bus2.shadow}, {2'b00, 1'b1, 1'b1, 4'b1010});
    @(negedge clk);
    chk("z_idle", {bus2.s, bus2.busy, bus2.done, bus2.shadow}, {2'b00, 1'b0, 1'b0, 4'b1010});

    // STOP in second WAIT; START mid-run ignored
    start2(4'b0011, 1'b0, 4'd4);
    @(negedge clk);
    bus2.start = 1'b1; bus2.pat = 4'b1111; bus2.dir = 1'b1; bus2.steps = 4'd1;
    @(negedge clk);
    bus2.start = 1'b0;
    chk("stopw_d_kept", bus2.d, 4'b0011);
    @(negedge clk);
    chk("stopw_step", bus2.s, 2'b01);
    @(negedge clk);
    chk("stopw_wait2", {bus2.s, bus2.shadow}, {2'b00, 4'b0110});
    bus2.stop = 1'b1;
    @(negedge clk);
    bus2.stop = 1'b0;
    chk("stopw_idle", {bus2.s, bus2.busy, bus2.done, bus2.d, bus2.shadow},
        {2'b00, 1'b0, 1'b0, 4'b0011, 4'b0110});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stopw_after%0d", i), {bus2.busy, bus2.done, bus2.shadow}, {1'b0, 1'b0, 4'b0110});
    end

    // STOP during STEP masks the rotate combinationally
    start2(4'b0101, 1'b1, 4'd2);
    repeat (3) @(negedge clk);
    chk("stops_step", bus2.s, 2'b10);
    bus2.stop = 1'b1;
    #1;
    chk("stops_masked", bus2.s, 2'b00);
    @(negedge clk);
    bus2.stop = 1'b0;
    chk("stops_idle", {bus2.busy, bus2.done, bus2.shadow}, {1'b0, 1'b0, 4'b0101});

    // Async reset during STEP, then a fresh run
    start2(4'b0001, 1'b0, 4'd3);
    repeat (3) @(negedge clk);
    chk("rst_pre_step", bus2.s, 2'b01);
    rst = 1'b1;
    #1;
    chk("rst_async", {bus2.s, bus2.d, bus2.oe, bus2.busy, bus2.done, bus2.shadow},
        {2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000});
    @(negedge clk);
    rst = 1'b0;
    start2(4'b0110, 1'b1, 4'd1);
    chk("rr_load", {bus2.s, bus2.d, bus2.oe}, {2'b11, 4'b0110, 1'b1});
    repeat (3) @(negedge clk);
    chk("rr_step", {bus2.s, bus2.oe, bus2.shadow}, {2'b10, 1'b0, 4'b0110});
    @(negedge clk);
    chk("rr_fin", {bus2.done, bus2.shadow}, {1'b1, 4'b0011});
    chk("rr_regq", reg_q, 4'b0011);
    @(negedge clk);
    chk("rr_idle", {bus2.busy, bus2.done}, {1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_shift_ctrl.md
# ring_shift_ctrl

Sequencing controller that sits directly upstream of the team's 4-bit rotate/load register and drives its mode-select, parallel-data and output-enable inputs. On a start command it parallel-loads a pattern, then issues a programmed number of single-cycle left or right rotate commands, one per prescaled tick. It keeps a shadow copy of the expected register contents so the pair can be checked end to end.

## Interface
- TICK_DIV, 4: idle cycles between rotate commands; legal range 1 to 2^TICK_W-1.
- TICK_W, 8: width of the prescaler counter.
- CLK  input  1  system clock, all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  begin a sequence; sampled only in IDLE.
- STOP  input  1  abort the running sequence.
- DIR  input  1  rotate direction: 0 = left, 1 = right.
- PAT  input  4  pattern to load.
- STEPS  input  4  number of rotations, 0 to 15.
- S  output  2  mode select to the register: 00 hold, 01 rotate left, 10 rotate right, 11 load.
- D  output  4  parallel load data.
- OE  output  1  tri-state control to the register, 1 = Q high-Z.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse when a sequence completes normally.
- SHADOW  output  4  expected register contents.

## Operation
- FSM states: IDLE, LOAD, WAIT, STEP, FIN. Outputs are Moore-decoded from the registered state. S=00 in every state except LOAD and STEP.
- IDLE:
  - When START=1 and STOP=0, latch PAT, DIR and STEPS into internal registers, then go to LOAD.
  - START while not in IDLE is ignored; the latched values do not change.
- LOAD: S=11, D=latched pattern; SHADOW<=pattern at the exiting edge; OE is cleared to 0 at that same edge. Next state is FIN if STEPS==0, else WAIT with the prescaler at 0.
- WAIT: the prescaler increments each cycle. When it equals TICK_DIV-1, go to STEP.
- STEP:
  - S=01 if DIR=0, else 10.
  - SHADOW rotates by the same rule as the register. Left: {SHADOW[2:0],SHADOW[3]}. Right: {SHADOW[0],SHADOW[3:1]}.
  - The remaining count decrements. If it reaches 0, go to FIN; else clear the prescaler and go to WAIT.
- FIN: DONE=1 for one cycle, then go to IDLE.
- STOP=1 in LOAD, WAIT or STEP forces IDLE at the next edge:
  - No rotate or load is issued that cycle; S is forced to 00 combinationally.
  - SHADOW keeps its last value and DONE is not asserted.
- STOP and START both high in IDLE: STOP wins and the FSM stays in IDLE.
- D holds the last latched pattern in all states. The register only consumes it when S=11.

## Timing
- Reset values: state=IDLE, S=00, D=0000, OE=1, BUSY=0, DONE=0, SHADOW=0000, prescaler=0, remaining count=0.
- OE stays 1 until the first completed LOAD, then stays 0 until reset.
- START sampled at edge k: LOAD occupies cycle k..k+1, so the register loads at edge k+1.
- Each rotation costs TICK_DIV WAIT cycles plus 1 STEP cycle.
- Total BUSY cycles = 2 + STEPS×(TICK_DIV+1).
- DONE is high in the cycle after the last STEP. A new START is accepted in the cycle after FIN.
- RST asserted mid-sequence: all outputs return to their reset values immediately (asynchronous). Treat the register contents as stale; OE=1 hides them until the next load.

## Structure
- Shared package/header holds:
  - S codes: S_HOLD=2'b00, S_ROTL=2'b01, S_ROTR=2'b10, S_LOAD=2'b11.
  - FSM state encodings.
- One sub-module, step_tick_gen: prescaler with clear, enable and TICK_DIV terminal-count output. Parameters TICK_DIV and TICK_W.
- Top level holds the FSM, latches and shadow rotator; it does not instantiate the register itself.

## Test plan
- Reset then idle 10 cycles → S=00, OE=1, BUSY=0, SHADOW=0000 throughout.
- TICK_DIV=2, PAT=0001, DIR=0, STEPS=3:
  - S sequence is 11,00,00,01,00,00,01,00,00,01, then DONE pulse.
  - SHADOW goes 0001→0010→0100→1000; paired register Q matches SHADOW after each step; OE=0 from the load onward.
- TICK_DIV=1, PAT=1000, DIR=1, STEPS=5 → SHADOW 0100,0010,0001,1000,0100; BUSY for exactly 12 cycles.
- STEPS=0, PAT=1010 → single S=11 cycle, DONE one cycle later, no 01/10 issued, SHADOW=1010.
- STOP during the second WAIT of a 4-step run → IDLE next edge, no DONE, SHADOW frozen after 1 rotation; START during that run ignored.
- RST pulsed during a STEP cycle → all outputs return to reset values immediately; a following START with PAT=0110 runs normally.
